core_avalon_bridge: RTL and testbench

- Responder for the core's start/ready load-store interface: `addr`, `start`, `write`, `data_wr` in; `ready`, `data_rd` out.
- Converts each core request into exactly one Avalon-MM master transaction on the platform interconnect.
- Sits between `ldst_switch` and `platform`, on the `data`/`io` ports. It is the bus-side end of the core's memory protocol.

---
 rtl/core_avalon_bridge.sv | 170 +++++++++++++++++
 tb/tb_core_avalon_bridge.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/core_avalon_bridge.sv
`default_nettype none
// ============================================================================
// core_avalon_bridge
// Turns each core start/ready load-store request into one Avalon-MM transaction.
// Optional macro BUS_TIMEOUT_EN adds a CMD/RDATA timeout reported on bus_err.
// Revision: 1.0
// ============================================================================
module core_avalon_bridge #(
   parameter int ADDR_W         = 30,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                write,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   data_wr,
   output logic                ready,
   output logic [DATA_W-1:0]   data_rd,
   output logic [ADDR_W+1:0]   avl_address,
   output logic                avl_read,
   output logic                avl_write,
   output logic [DATA_W-1:0]   avl_writedata,
   output logic [3:0]          avl_byteenable,
   input  logic                avl_waitrequest,
   input  logic [DATA_W-1:0]   avl_readdata,
   input  logic                avl_readdatavalid,
   output logic                bus_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMD   = 2'd1,
      RDATA = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                is_write_q, is_write_d;
   logic                ready_q, ready_d;
   logic                bus_err_q, bus_err_d;
   logic [DATA_W-1:0]   data_rd_q, data_rd_d;
   logic [ADDR_W+1:0]   avl_address_q, avl_address_d;
   logic                avl_read_q, avl_read_d;
   logic                avl_write_q, avl_write_d;
   logic [DATA_W-1:0]   avl_writedata_q, avl_writedata_d;
   logic                timeout;

`ifdef BUS_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 10) ? 10 : $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d         = state_q;
      is_write_d      = is_write_q;
      ready_d         = 1'b0;
      bus_err_d       = 1'b0;
      data_rd_d       = data_rd_q;
      avl_address_d   = avl_address_q;
      avl_read_d      = avl_read_q;
      avl_write_d     = avl_write_q;
      avl_writedata_d = avl_writedata_q;
`ifdef BUS_TIMEOUT_EN
      cnt_d           = (state_q == IDLE) ? cnt_q : cnt_q + CNT_W'(1);
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d         = CMD;
               is_write_d      = write;
               avl_address_d   = {addr, 2'b00};
               avl_read_d      = !write;
               avl_write_d     = write;
               avl_writedata_d = data_wr;
`ifdef BUS_TIMEOUT_EN
               cnt_d           = '0;
`endif
            end
         end
         CMD: begin
            // A normal accept on the limit cycle takes priority over the timeout.
            if (!avl_waitrequest) begin
               avl_read_d  = 1'b0;
               avl_write_d = 1'b0;
               if (is_write_q) begin
                  ready_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = RDATA;
               end
            end else if (timeout) begin
               avl_read_d  = 1'b0;
               avl_write_d = 1'b0;
               ready_d     = 1'b1;
               bus_err_d   = 1'b1;
               if (!is_write_q) data_rd_d = '1;
               state_d     = IDLE;
            end
         end
         RDATA: begin
            if (avl_readdatavalid) begin
               data_rd_d = avl_readdata;
               ready_d   = 1'b1;
               state_d   = IDLE;
            end else if (timeout) begin
               data_rd_d = '1;
               ready_d   = 1'b1;
               bus_err_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         is_write_q      <= 1'b0;
         ready_q         <= 1'b0;
         bus_err_q       <= 1'b0;
         data_rd_q       <= '0;
         avl_address_q   <= '0;
         avl_read_q      <= 1'b0;
         avl_write_q     <= 1'b0;
         avl_writedata_q <= '0;
      end else begin
         state_q         <= state_d;
         is_write_q      <= is_write_d;
         ready_q         <= ready_d;
         bus_err_q       <= bus_err_d;
         data_rd_q       <= data_rd_d;
         avl_address_q   <= avl_address_d;
         avl_read_q      <= avl_read_d;
         avl_write_q     <= avl_write_d;
         avl_writedata_q <= avl_writedata_d;
      end
   end

   assign ready          = ready_q;
   assign bus_err        = bus_err_q;
   assign data_rd        = data_rd_q;
   assign avl_address    = avl_address_q;
   assign avl_read       = avl_read_q;
   assign avl_write      = avl_write_q;
   assign avl_writedata  = avl_writedata_q;
   assign avl_byteenable = 4'hF;

`ifndef SYNTHESIS
   // A new request while busy is dropped by the FSM; flag it for the core designer.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(start && state_q != IDLE))
            else $warning("core_avalon_bridge: start ignored while busy");
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_avalon_bridge.sv
`default_nettype none
// ============================================================================
// tb_core_avalon_bridge
// Table-driven bench with a scoreboard queue for core_avalon_bridge.
// Revision: 1.0
// ============================================================================
module tb_core_avalon_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        write = 1'b0;
   logic [29:0] addr = '0;
   logic [31:0] data_wr = '0;
   logic        ready;
   logic [31:0] data_rd;
   logic [31:0] avl_address;
   logic        avl_read;
   logic        avl_write;
   logic [31:0] avl_writedata;
   logic [3:0]  avl_byteenable;
   logic        avl_waitrequest = 1'b0;
   logic [31:0] avl_readdata = '0;
   logic        avl_readdatavalid = 1'b0;
   logic        bus_err;

   core_avalon_bridge #(
      .ADDR_W         (30),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start             (start),
      .write             (write),
      .addr              (addr),
      .data_wr           (data_wr),
      .ready             (ready),
      .data_rd           (data_rd),
      .avl_address       (avl_address),
      .avl_read          (avl_read),
      .avl_write         (avl_write),
      .avl_writedata     (avl_writedata),
      .avl_byteenable    (avl_byteenable),
      .avl_waitrequest   (avl_waitrequest),
      .avl_readdata      (avl_readdata),
      .avl_readdatavalid (avl_readdatavalid),
      .bus_err           (bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [29:0] a;
      logic [31:0] wdata;
      int          nwait;
      int          rdly;
      logic [31:0] rdata;
      int          stray;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_rd = '0;
   logic [31:0] sb_q[$];
   vec_t        vecs[6];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Entered at a negedge with the DUT idle; returns at the negedge of the ready cycle.
   task automatic run_txn(input vec_t v, input int idx);
      int          acc = v.nwait + 1;
      int          lat = v.wr ? acc + 1 : acc + v.rdly + 1;
      int          got = -1;
      logic [31:0] ebyte;
      logic [31:0] exp_d;
      ebyte = {v.a, 2'b00};
      if (!v.wr) exp_rd = v.rdata;
      sb_q.push_back(exp_rd);
      start = 1'b1; write = v.wr; addr = v.a; data_wr = v.wdata;
      avl_waitrequest = 1'b0; avl_readdatavalid = 1'b0;
      for (int c = 1; c <= 40 && got < 0; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == v.stray) begin
            start = 1'b1; write = 1'b1; addr = 30'h3FF; data_wr = 32'h0;
         end
         avl_waitrequest   = (c <= v.nwait);
         avl_readdatavalid = (!v.wr && c == acc + v.rdly);
         avl_readdata      = avl_readdatavalid ? v.rdata : 32'hDEAD_BEEF;
         if (c <= acc) begin
            chk($sformatf("v%0d cmd c%0d", idx, c), {avl_read, avl_write, avl_address},
                {!v.wr, v.wr, ebyte});
            if (v.wr) chk($sformatf("v%0d wdata c%0d", idx, c), avl_writedata, v.wdata);
         end
         if (c == acc + 1)
            chk($sformatf("v%0d cmd_drop", idx), {avl_read, avl_write}, 2'b00);
         if (ready) got = c;
      end
      start = 1'b0;
      avl_readdatavalid = 1'b0;
      chk($sformatf("v%0d latency", idx), got, lat);
      exp_d = sb_q.pop_front();
      if (got >= 0) begin
         chk($sformatf("v%0d data_rd", idx), data_rd, exp_d);
         chk($sformatf("v%0d bus_err", idx), bus_err, 1'b0);
      end
   endtask

   initial begin
      int saw_ready;
      vecs[0] = '{1'b1, 30'h10,       32'hCAFE_BABE, 0, 0, 32'h0,         -1};
      vecs[1] = '{1'b0, 30'h20,       32'h0,         3, 2, 32'h1234_5678, -1};
      vecs[2] = '{1'b1, 30'h5,        32'h0BAD_F00D, 1, 0, 32'h0,         -1};
      vecs[3] = '{1'b0, 30'h1,        32'h0,         0, 1, 32'hA5A5_A5A5, -1};
      vecs[4] = '{1'b0, 30'h3FFF_FFFF, 32'h0,        2, 3, 32'h0F0F_1234,  5};
      vecs[5] = '{1'b1, 30'h0,        32'h1111_2222, 0, 0, 32'h0,         -1};

      repeat (3) @(negedge clk);
      chk("reset outs", {ready, avl_read, avl_write, bus_err, avl_byteenable}, 8'h0F);
      chk("reset data", {data_rd, avl_address, avl_writedata}, 96'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Consecutive calls start each request in the previous ready cycle.
      for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

      @(negedge clk);
      chk("post stray start", {ready, avl_read, avl_write}, 3'b000);

      avl_readdatavalid = 1'b1; avl_readdata = 32'h1357_9BDF;
      @(negedge clk);
      avl_readdatavalid = 1'b0;
      chk("stray rdv ready", ready, 1'b0);
      @(negedge clk);
      chk("stray rdv data", {ready, data_rd}, {1'b0, exp_rd});

      start = 1'b1; write = 1'b0; addr = 30'h44; avl_waitrequest = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("rst pre read", avl_read, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst async", {avl_read, ready}, 2'b00);
      saw_ready = 0;
      @(negedge clk);
      rst_n = 1'b1; avl_waitrequest = 1'b0;
      @(negedge clk);
      avl_readdatavalid = 1'b1; avl_readdata = 32'h9999_9999;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         avl_readdatavalid = 1'b0;
         if (ready) saw_ready++;
      end
      chk("rst no ready", saw_ready, 0);
      chk("rst data_rd", data_rd, 32'h0);
      exp_rd = '0;
      run_txn('{1'b0, 30'h44, 32'h0, 0, 1, 32'h0000_0077, -1}, 6);

`ifdef BUS_TIMEOUT_EN
      begin
         int got;
         got = -1;
         start = 1'b1; write = 1'b0; addr = 30'h8; avl_waitrequest = 1'b1;
         for (int c = 1; c <= 14 && got < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (ready) begin
               got = c;
               chk("to flags", {bus_err, avl_read}, 2'b10);
               chk("to data_rd", data_rd, 32'hFFFF_FFFF);
            end
         end
         avl_waitrequest = 1'b0;
         chk("to latency", got, 10);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
